can_tx_sched: RTL and testbench
===============================

CAN_TX_SCHED -- requirements
Module: can_tx_sched

Interface
REQ-001 Parameter NUM_MB, default 4, number of transmit mailboxes sharing one can_tx.
REQ-002 Parameter CLKS_PER_BIT, default 10, clocks per CAN bit; must match can_tx.
REQ-003 Parameter IFS_BITS, default 3, interframe gap length in bit times.
REQ-004 Parameter MAX_RETRIES, default 8, retry limit; used only under CAN_SCHED_RETRY_LIMIT_EN.
REQ-005 i_Clock  input  1  sole clock; all logic on the rising edge.
REQ-006 i_Reset  input  1  reset, synchronous, active-high.
REQ-007 i_Req_DV  input  NUM_MB  per-mailbox one-cycle load strobe.
REQ-008 i_Req_Id  input  NUM_MB*11  standard identifier per mailbox; mailbox k at bits [11k+10:11k].
REQ-009 i_Req_Dlc  input  NUM_MB*4  data length code per mailbox.
REQ-010 i_Req_Data  input  NUM_MB*64  payload per mailbox.
REQ-011 o_Req_Busy  output  NUM_MB  mailbox pending or in flight.
REQ-012 o_Done  output  NUM_MB  one-cycle pulse when a mailbox frame is sent.
REQ-013 o_Abort  output  NUM_MB  one-cycle pulse when a mailbox is dropped after its retry limit.
REQ-014 o_Tx_DV  output  1  one-cycle start strobe to can_tx.
REQ-015 o_Tx_Id / o_Tx_Dlc / o_Tx_Data  output  11/4/64  frame fields, stable from o_Tx_DV until WAIT exits.
REQ-016 i_Tx_Done  input  1  can_tx pulse: frame completed and acknowledged.
REQ-017 i_Arb_Lost  input  1  can_tx pulse: arbitration lost.
REQ-018 o_Sched_Idx  output  clog2(NUM_MB)  index of the mailbox currently selected.

Function
REQ-019 i_Req_DV[k] with o_Req_Busy[k]=0 SHALL capture the mailbox ID/DLC/data and set Busy[k] next cycle; a strobe while Busy[k]=1 SHALL be ignored.
REQ-020 FSM states: IDLE, SELECT, LAUNCH, WAIT, GAP.
REQ-021 IDLE->SELECT when any mailbox is pending and not in flight.
REQ-022 SELECT SHALL register the winner: lowest ID; on equal IDs, lowest index.
REQ-023 SELECT->LAUNCH next cycle; LAUNCH SHALL assert o_Tx_DV exactly one cycle, then go to WAIT.
REQ-024 WAIT on i_Tx_Done: pulse o_Done[idx], clear Busy[idx], go to GAP.
REQ-025 WAIT on i_Arb_Lost: keep Busy[idx], increment the retry count of idx, go to GAP.
REQ-026 i_Tx_Done and i_Arb_Lost in the same cycle SHALL be treated as done.
REQ-027 GAP SHALL last exactly IFS_BITS*CLKS_PER_BIT cycles, then go to IDLE; re-selection SHALL re-evaluate all pending mailboxes, including new arrivals.
REQ-028 Latency from a load into an idle scheduler to o_Tx_DV SHALL be 3 cycles: capture, IDLE->SELECT, LAUNCH.
REQ-029 The retry counter is 4 bits, saturates at 15, and clears on done, abort, or a new load.

Reset
REQ-030 Reset SHALL clear all outputs, Busy, retry counters, gap counter and o_Sched_Idx to 0, and force IDLE next cycle, including mid-frame; i_Tx_Done or i_Arb_Lost in the reset cycle SHALL be ignored.

Configuration
REQ-031 CAN_SCHED_RETRY_LIMIT_EN defined: on arbitration loss when the retry count reaches MAX_RETRIES, pulse o_Abort[idx], clear Busy[idx], go to GAP.
REQ-032 CAN_SCHED_RETRY_LIMIT_EN undefined: retries SHALL be unlimited and o_Abort SHALL be tied to 0.

Structure
REQ-033 Package can_pkg SHALL hold ID_W=11, DLC_W=4, DATA_W=64 and the FSM state encoding.
REQ-034 Sub-module can_prio_sel SHALL be combinational: inputs pending mask and IDs; outputs the winner index and a valid flag.

Verification
REQ-035 Load MB2 with ID 0x123 while idle -> o_Tx_DV 3 cycles later, o_Tx_Id=0x123, o_Sched_Idx=2; i_Tx_Done -> o_Done=4'b0100.
REQ-036 Load MB0 with 0x200, MB1 with 0x100, MB3 with 0x100 in the same cycle -> transmission order MB1, MB3, MB0.
REQ-037 i_Arb_Lost on MB1 -> after a 30-cycle gap, MB1 is relaunched and Busy[1] stays 1 throughout.
REQ-038 With the macro defined, MAX_RETRIES=2: three losses on MB0 -> o_Abort=4'b0001 and Busy[0]=0; without the macro, 10 losses -> still retrying.
REQ-039 Assert i_Reset during WAIT -> next cycle all outputs 0 and state IDLE; a later i_Tx_Done produces no o_Done.
REQ-040 i_Tx_Done and i_Arb_Lost in the same cycle -> o_Done pulses and no retry occurs.

Source files
------------

// File: rtl/can_pkg.sv
// can_pkg: shared field widths, retry counter width, scheduler state encoding
// and the frame payload carried from a mailbox to can_tx.
package can_pkg;

    localparam int unsigned ID_W    = 11;
    localparam int unsigned DLC_W   = 4;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned RETRY_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_GAP    = 3'd4
    } sched_state_e;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DLC_W-1:0]  dlc;
        logic [DATA_W-1:0] data;
    } can_frame_t;

endpackage

// File: rtl/can_tx_sched_if.sv
// can_tx_sched_if: mailbox request side and can_tx launch side of the scheduler.
//   master : environment / CAN controller host (drives requests and can_tx status)
//   slave  : can_tx_sched
// Signals: i_Req_DV/i_Req_Id/i_Req_Dlc/i_Req_Data (per-mailbox loads),
//          o_Req_Busy/o_Done/o_Abort (per-mailbox status),
//          o_Tx_DV/o_Tx_Id/o_Tx_Dlc/o_Tx_Data (frame launch),
//          i_Tx_Done/i_Arb_Lost (can_tx result), o_Sched_Idx (selected mailbox).
interface can_tx_sched_if #(
    parameter int unsigned NUM_MB = 4
) ();
    import can_pkg::*;

    localparam int unsigned IDX_W = (NUM_MB > 1) ? $clog2(NUM_MB) : 1;

    logic [NUM_MB-1:0]        i_Req_DV;
    logic [NUM_MB*ID_W-1:0]   i_Req_Id;
    logic [NUM_MB*DLC_W-1:0]  i_Req_Dlc;
    logic [NUM_MB*DATA_W-1:0] i_Req_Data;
    logic [NUM_MB-1:0]        o_Req_Busy;
    logic [NUM_MB-1:0]        o_Done;
    logic [NUM_MB-1:0]        o_Abort;
    logic                     o_Tx_DV;
    logic [ID_W-1:0]          o_Tx_Id;
    logic [DLC_W-1:0]         o_Tx_Dlc;
    logic [DATA_W-1:0]        o_Tx_Data;
    logic                     i_Tx_Done;
    logic                     i_Arb_Lost;
    logic [IDX_W-1:0]         o_Sched_Idx;

    modport master (
        output i_Req_DV, i_Req_Id, i_Req_Dlc, i_Req_Data, i_Tx_Done, i_Arb_Lost,
        input  o_Req_Busy, o_Done, o_Abort, o_Tx_DV, o_Tx_Id, o_Tx_Dlc, o_Tx_Data,
               o_Sched_Idx
    );

    modport slave (
        input  i_Req_DV, i_Req_Id, i_Req_Dlc, i_Req_Data, i_Tx_Done, i_Arb_Lost,
        output o_Req_Busy, o_Done, o_Abort, o_Tx_DV, o_Tx_Id, o_Tx_Dlc, o_Tx_Data,
               o_Sched_Idx
    );

endinterface

// File: rtl/can_prio_sel.sv
// can_prio_sel: combinational CAN priority pick among pending mailboxes.
// Lowest identifier wins (CAN dominant-bit priority); ties go to the lowest index.
//   i_Pending   : pending mailbox mask
//   i_Ids       : packed identifiers, mailbox k at [k*ID_W +: ID_W]
//   o_Win_Idx   : winning mailbox index
//   o_Win_Valid : at least one mailbox pending
module can_prio_sel
    import can_pkg::*;
#(
    parameter int unsigned NUM_MB = 4,
    parameter int unsigned IDX_W  = (NUM_MB > 1) ? $clog2(NUM_MB) : 1
) (
    input  logic [NUM_MB-1:0]      i_Pending,
    input  logic [NUM_MB*ID_W-1:0] i_Ids,
    output logic [IDX_W-1:0]       o_Win_Idx,
    output logic                   o_Win_Valid
);

    logic [ID_W-1:0] best_id;

    // Strict less-than keeps the earlier (lower) index on equal identifiers.
    always_comb begin
        o_Win_Idx   = '0;
        o_Win_Valid = 1'b0;
        best_id     = '1;
        for (int k = 0; k < NUM_MB; k++) begin
            if (i_Pending[k] && (!o_Win_Valid || (i_Ids[k*ID_W +: ID_W] < best_id))) begin
                o_Win_Valid = 1'b1;
                o_Win_Idx   = IDX_W'(k);
                best_id     = i_Ids[k*ID_W +: ID_W];
            end
        end
    end

endmodule

// File: rtl/can_tx_sched.sv
// can_tx_sched: shares one can_tx among NUM_MB transmit mailboxes.
// Mailboxes are loaded by one-cycle strobes; the scheduler picks the highest
// priority pending frame, launches it, waits for done / arbitration loss, then
// holds off for the interframe gap before re-selecting.
//   i_Clock : clock, rising edge
//   i_Reset : synchronous active-high reset
//   bus     : can_tx_sched_if.slave (mailbox requests, status, can_tx launch/result)
// Build option: CAN_SCHED_RETRY_LIMIT_EN -- drop a mailbox (o_Abort) after
// MAX_RETRIES arbitration losses; undefined means unlimited retries, o_Abort = 0.
module can_tx_sched
    import can_pkg::*;
#(
    parameter int unsigned NUM_MB       = 4,
    parameter int unsigned CLKS_PER_BIT = 10,
    parameter int unsigned IFS_BITS     = 3,
    parameter int unsigned MAX_RETRIES  = 8
) (
    input  logic          i_Clock,
    input  logic          i_Reset,
    can_tx_sched_if.slave bus
);

    localparam int unsigned IDX_W   = (NUM_MB > 1) ? $clog2(NUM_MB) : 1;
    localparam int unsigned GAP_CYC = IFS_BITS * CLKS_PER_BIT;
    localparam int unsigned GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    sched_state_e           state_q;
    logic [NUM_MB-1:0]      busy_q;
    logic [RETRY_W-1:0]     retry_q [NUM_MB];
    logic [GAP_W-1:0]       gap_cnt_q;
    logic [IDX_W-1:0]       idx_q;
    can_frame_t             mb_q [NUM_MB];
    logic [NUM_MB*ID_W-1:0] mb_ids;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_valid;

`ifndef CAN_SCHED_RETRY_LIMIT_EN
    logic unused_max_retries;
    assign unused_max_retries = (MAX_RETRIES != 0);
`endif

    assign bus.o_Req_Busy  = busy_q;
    assign bus.o_Sched_Idx = idx_q;

    // Mailbox storage: captured only when the mailbox is free.
    always_ff @(posedge i_Clock) begin
        for (int k = 0; k < NUM_MB; k++) begin
            if (bus.i_Req_DV[k] && !busy_q[k]) begin
                mb_q[k].id   <= bus.i_Req_Id[k*ID_W +: ID_W];
                mb_q[k].dlc  <= bus.i_Req_Dlc[k*DLC_W +: DLC_W];
                mb_q[k].data <= bus.i_Req_Data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Flatten stored identifiers for the priority picker.
    always_comb begin
        mb_ids = '0;
        for (int k = 0; k < NUM_MB; k++) begin
            mb_ids[k*ID_W +: ID_W] = mb_q[k].id;
        end
    end

    can_prio_sel #(
        .NUM_MB (NUM_MB),
        .IDX_W  (IDX_W)
    ) u_prio_sel (
        .i_Pending   (busy_q),
        .i_Ids       (mb_ids),
        .o_Win_Idx   (win_idx),
        .o_Win_Valid (win_valid)
    );

    // Scheduler FSM with busy/retry bookkeeping and registered launch/status outputs.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q       <= ST_IDLE;
            busy_q        <= '0;
            gap_cnt_q     <= '0;
            idx_q         <= '0;
            for (int k = 0; k < NUM_MB; k++) begin
                retry_q[k] <= '0;
            end
            bus.o_Done    <= '0;
            bus.o_Abort   <= '0;
            bus.o_Tx_DV   <= 1'b0;
            bus.o_Tx_Id   <= '0;
            bus.o_Tx_Dlc  <= '0;
            bus.o_Tx_Data <= '0;
        end else begin
            bus.o_Done  <= '0;
            bus.o_Abort <= '0;
            bus.o_Tx_DV <= 1'b0;

            for (int k = 0; k < NUM_MB; k++) begin
                if (bus.i_Req_DV[k] && !busy_q[k]) begin
                    busy_q[k]  <= 1'b1;
                    retry_q[k] <= '0;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (|busy_q) begin
                        state_q <= ST_SELECT;
                    end
                end
                // Frame fields are latched here and held until the next SELECT,
                // so they stay stable for the whole LAUNCH/WAIT window.
                ST_SELECT: begin
                    if (win_valid) begin
                        idx_q         <= win_idx;
                        bus.o_Tx_Id   <= mb_q[win_idx].id;
                        bus.o_Tx_Dlc  <= mb_q[win_idx].dlc;
                        bus.o_Tx_Data <= mb_q[win_idx].data;
                        bus.o_Tx_DV   <= 1'b1;
                        state_q       <= ST_LAUNCH;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_LAUNCH: begin
                    state_q <= ST_WAIT;
                end
                // Done has priority over a simultaneous arbitration loss.
                ST_WAIT: begin
                    if (bus.i_Tx_Done) begin
                        bus.o_Done[idx_q] <= 1'b1;
                        busy_q[idx_q]     <= 1'b0;
                        retry_q[idx_q]    <= '0;
                        gap_cnt_q         <= GAP_W'(GAP_CYC - 1);
                        state_q           <= ST_GAP;
                    end else if (bus.i_Arb_Lost) begin
`ifdef CAN_SCHED_RETRY_LIMIT_EN
                        if (32'(retry_q[idx_q]) >= MAX_RETRIES) begin
                            bus.o_Abort[idx_q] <= 1'b1;
                            busy_q[idx_q]      <= 1'b0;
                            retry_q[idx_q]     <= '0;
                        end else if (retry_q[idx_q] != '1) begin
                            retry_q[idx_q] <= retry_q[idx_q] + RETRY_W'(1);
                        end
`else
                        if (retry_q[idx_q] != '1) begin
                            retry_q[idx_q] <= retry_q[idx_q] + RETRY_W'(1);
                        end
`endif
                        gap_cnt_q <= GAP_W'(GAP_CYC - 1);
                        state_q   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_can_tx_sched.sv
// tb_can_tx_sched: scoreboard bench for can_tx_sched. The reference keeps the
// mailbox contents and pending set as plain arrays and predicts each launch as
// the pending mailbox with the smallest identifier (lowest index on ties).
module tb_can_tx_sched;
    import can_pkg::*;

    localparam int unsigned NUM_MB       = 4;
    localparam int unsigned CLKS_PER_BIT = 10;
    localparam int unsigned IFS_BITS     = 3;
    localparam int unsigned GAP_CYC      = IFS_BITS * CLKS_PER_BIT;
`ifdef CAN_SCHED_RETRY_LIMIT_EN
    localparam int unsigned MAX_RETRIES  = 2;
    localparam int          LOSS_RUN     = 3;
    localparam logic [3:0]  LOSS_ABORT   = 4'b0001;
    localparam logic        LOSS_BUSY    = 1'b0;
`else
    localparam int unsigned MAX_RETRIES  = 8;
    localparam int          LOSS_RUN     = 10;
    localparam logic [3:0]  LOSS_ABORT   = 4'b0000;
    localparam logic        LOSS_BUSY    = 1'b1;
`endif

    typedef struct {
        int          idx;
        logic [10:0] id;
        logic [3:0]  dlc;
        logic [63:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    can_tx_sched_if #(.NUM_MB(NUM_MB)) bus ();

    can_tx_sched #(
        .NUM_MB       (NUM_MB),
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .IFS_BITS     (IFS_BITS),
        .MAX_RETRIES  (MAX_RETRIES)
    ) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference mailbox state
    bit          m_busy  [NUM_MB];
    logic [10:0] m_id    [NUM_MB];
    logic [3:0]  m_dlc   [NUM_MB];
    logic [63:0] m_data  [NUM_MB];
    int          m_retry [NUM_MB];
    logic [10:0] s_id    [NUM_MB];
    logic [3:0]  s_dlc   [NUM_MB];
    logic [63:0] s_data  [NUM_MB];
    int          cur_idx = 0;

    exp_t              exp_q[$];
    logic [NUM_MB-1:0] done_q[$];
    logic [NUM_MB-1:0] abort_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    function automatic logic [NUM_MB-1:0] busy_mask();
        logic [NUM_MB-1:0] m = '0;
        for (int k = 0; k < NUM_MB; k++) m[k] = m_busy[k];
        return m;
    endfunction

    function automatic int pick();
        int w = -1;
        for (int k = 0; k < NUM_MB; k++)
            if (m_busy[k] && (w < 0 || m_id[k] < m_id[w])) w = k;
        return w;
    endfunction

    task automatic push_next();
        int w = pick();
        if (w >= 0) begin
            exp_q.push_back('{w, m_id[w], m_dlc[w], m_data[w]});
            cur_idx = w;
        end
    endtask

    task automatic stage(input int k, input logic [10:0] id, input logic [3:0] dlc,
                         input logic [63:0] data);
        s_id[k] = id; s_dlc[k] = dlc; s_data[k] = data;
        bus.i_Req_Id[k*11 +: 11]   = id;
        bus.i_Req_Dlc[k*4 +: 4]    = dlc;
        bus.i_Req_Data[k*64 +: 64] = data;
    endtask

    task automatic stage_random();
        for (int k = 0; k < NUM_MB; k++)
            stage(k, ($urandom_range(0, 1) == 1) ? 11'($urandom_range(0, 3)) : 11'($urandom),
                  4'($urandom_range(0, 8)), {$urandom, $urandom});
    endtask

    // One-cycle load strobe; a free mailbox takes the staged fields.
    task automatic do_load(input logic [NUM_MB-1:0] mask);
        bus.i_Req_DV = mask;
        for (int k = 0; k < NUM_MB; k++) begin
            if (mask[k] && !m_busy[k]) begin
                m_busy[k] = 1; m_id[k] = s_id[k]; m_dlc[k] = s_dlc[k];
                m_data[k] = s_data[k]; m_retry[k] = 0;
            end
        end
        @(negedge clk);
        bus.i_Req_DV = '0;
    endtask

    task automatic wait_launch(output int n, output bit held, input int idx);
        n = 0; held = 1;
        forever begin
            @(negedge clk);
            n++;
            if (!bus.o_Req_Busy[idx]) held = 0;
            if (bus.o_Tx_DV === 1'b1) break;
            if (n > 500) begin
                chk("launch_timeout", 64'(n), 64'(0));
                finish_sim();
            end
        end
    endtask

    // can_tx result: kind 0 = done, 1 = arbitration lost, 2 = both at once.
    task automatic respond(input int kind, input bit extra_load);
        logic [NUM_MB-1:0] m = '0;
        repeat ($urandom_range(1, 6)) @(negedge clk);
        if (extra_load) begin
            stage_random();
            do_load(4'($urandom_range(1, 15)));
        end
        bus.i_Tx_Done  = (kind != 1);
        bus.i_Arb_Lost = (kind != 0);
        m[cur_idx] = 1'b1;
        if (kind != 1) begin
            done_q.push_back(m);
            m_busy[cur_idx] = 0; m_retry[cur_idx] = 0;
        end else begin
`ifdef CAN_SCHED_RETRY_LIMIT_EN
            if (m_retry[cur_idx] >= int'(MAX_RETRIES)) begin
                abort_q.push_back(m);
                m_busy[cur_idx] = 0; m_retry[cur_idx] = 0;
            end else begin
                m_retry[cur_idx] = (m_retry[cur_idx] < 15) ? m_retry[cur_idx] + 1 : 15;
            end
`else
            m_retry[cur_idx] = (m_retry[cur_idx] < 15) ? m_retry[cur_idx] + 1 : 15;
`endif
        end
        push_next();
        @(negedge clk);
        bus.i_Tx_Done  = 1'b0;
        bus.i_Arb_Lost = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},  64'(bus.o_Req_Busy),  64'(0));
        chk({tag, "_done"},  64'(bus.o_Done),      64'(0));
        chk({tag, "_abort"}, 64'(bus.o_Abort),     64'(0));
        chk({tag, "_txdv"},  64'(bus.o_Tx_DV),     64'(0));
        chk({tag, "_idx"},   64'(bus.o_Sched_Idx), 64'(0));
        chk({tag, "_txid"},  64'(bus.o_Tx_Id),     64'(0));
        chk({tag, "_data"},  bus.o_Tx_Data,        64'(0));
    endtask

    // Monitor: every DUT launch / done / abort pulse is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.o_Tx_DV === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_launch: got idx %0d, expected no launch", bus.o_Sched_Idx);
            end else begin
                e = exp_q.pop_front();
                chk("launch_idx",  64'(bus.o_Sched_Idx), 64'(e.idx));
                chk("launch_id",   64'(bus.o_Tx_Id),     64'(e.id));
                chk("launch_dlc",  64'(bus.o_Tx_Dlc),    64'(e.dlc));
                chk("launch_data", bus.o_Tx_Data,        e.data);
            end
        end
        if (!rst && bus.o_Done != '0) begin
            if (done_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got 0x%0h, expected none", bus.o_Done);
            end else chk("done_mask", 64'(bus.o_Done), 64'(done_q.pop_front()));
        end
        if (!rst && bus.o_Abort != '0) begin
            if (abort_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_abort: got 0x%0h, expected none", bus.o_Abort);
            end else chk("abort_mask", 64'(bus.o_Abort), 64'(abort_q.pop_front()));
        end
    end

    initial begin
        int n;
        bit held;
        logic [3:0] seen;
        rst = 1'b1;
        bus.i_Req_DV = '0; bus.i_Req_Id = '0; bus.i_Req_Dlc = '0; bus.i_Req_Data = '0;
        bus.i_Tx_Done = 1'b0; bus.i_Arb_Lost = 1'b0;
        for (int k = 0; k < NUM_MB; k++) begin
            m_busy[k] = 0; m_retry[k] = 0; m_id[k] = '0; m_dlc[k] = '0; m_data[k] = '0;
        end
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single load into idle scheduler: 3-cycle latency, one-cycle strobe
        stage(2, 11'h123, 4'd8, 64'h0123_4567_89AB_CDEF);
        do_load(4'b0100);
        push_next();
        chk("busy_after_load", 64'(bus.o_Req_Busy), 64'(4'b0100));
        wait_launch(n, held, 2);
        chk("load_to_launch_latency", 64'(n + 1), 64'(3));
        @(negedge clk);
        chk("tx_dv_one_cycle", 64'(bus.o_Tx_DV), 64'(0));
        respond(0, 0);
        chk("done_mb2", 64'(bus.o_Done), 64'(4'b0100));
        chk("busy_after_done", 64'(bus.o_Req_Busy), 64'(busy_mask()));

        // Priority: lower id first, equal ids by index
        repeat (GAP_CYC + 4) @(negedge clk);
        stage(0, 11'h200, 4'd1, 64'hA0);
        stage(1, 11'h100, 4'd2, 64'hA1);
        stage(3, 11'h100, 4'd3, 64'hA3);
        do_load(4'b1011);
        push_next();
        for (int i = 0; i < 3; i++) begin
            wait_launch(n, held, cur_idx);
            respond(0, 0);
        end

        // Arbitration loss: relaunch after the full gap, busy held throughout
        repeat (GAP_CYC + 4) @(negedge clk);
        stage(1, 11'h055, 4'd4, 64'hB1);
        do_load(4'b0010);
        push_next();
        wait_launch(n, held, 1);
        respond(1, 0);
        wait_launch(n, held, 1);
        chk("relaunch_after_gap", 64'(n + 1), 64'(GAP_CYC + 3));
        chk("busy1_held_in_gap", 64'(held), 64'(1));
        respond(0, 0);

        // Done and arbitration loss together count as done
        repeat (GAP_CYC + 4) @(negedge clk);
        stage(0, 11'h010, 4'd5, 64'hC0);
        do_load(4'b0001);
        push_next();
        wait_launch(n, held, 0);
        respond(2, 0);
        chk("both_is_done", 64'(bus.o_Done), 64'(4'b0001));
        repeat (GAP_CYC + 10) @(negedge clk);
        chk("both_no_retry", 64'(bus.o_Req_Busy), 64'(0));

        // Repeated losses on MB0
        stage(0, 11'h3FF, 4'd6, 64'hD0);
        do_load(4'b0001);
        push_next();
        for (int i = 0; i < LOSS_RUN; i++) begin
            wait_launch(n, held, 0);
            respond(1, 0);
        end
        chk("loss_run_abort", 64'(bus.o_Abort), 64'(LOSS_ABORT));
        chk("loss_run_busy0", 64'(bus.o_Req_Busy[0]), 64'(LOSS_BUSY));
        if (m_busy[0]) begin
            wait_launch(n, held, 0);
            respond(0, 0);
        end

        // Reset while waiting for can_tx; a done in the reset cycle and later is ignored
        repeat (GAP_CYC + 4) @(negedge clk);
        stage(3, 11'h077, 4'd7, 64'hE3);
        do_load(4'b1000);
        push_next();
        wait_launch(n, held, 3);
        @(negedge clk);
        rst = 1'b1;
        bus.i_Tx_Done = 1'b1;
        for (int k = 0; k < NUM_MB; k++) begin m_busy[k] = 0; m_retry[k] = 0; end
        @(negedge clk);
        rst = 1'b0;
        bus.i_Tx_Done = 1'b0;
        check_zero("reset_in_wait");
        repeat (3) @(negedge clk);
        bus.i_Tx_Done = 1'b1;
        seen = '0;
        @(negedge clk);
        bus.i_Tx_Done = 1'b0;
        seen |= bus.o_Done;
        repeat (3) begin @(negedge clk); seen |= bus.o_Done; end
        chk("no_done_after_reset", 64'(seen), 64'(0));
        chk("idle_after_reset", 64'(bus.o_Req_Busy), 64'(0));

        // Randomized traffic with loads arriving during WAIT
        for (int it = 0; it < 25; it++) begin
            repeat ($urandom_range(0, 40)) @(negedge clk);
            stage_random();
            do_load(4'($urandom_range(1, 15)));
            push_next();
            while (pick() >= 0) begin
                wait_launch(n, held, cur_idx);
                respond(($urandom_range(0, 9) < 6) ? 0 : (($urandom_range(0, 3) == 0) ? 2 : 1),
                        ($urandom_range(0, 2) == 0));
                chk("busy_mask_random", 64'(bus.o_Req_Busy), 64'(busy_mask()));
            end
        end

        repeat (GAP_CYC + 10) @(negedge clk);
        chk("launches_drained", 64'(exp_q.size()), 64'(0));
        chk("dones_drained", 64'(done_q.size()), 64'(0));
        chk("aborts_drained", 64'(abort_q.size()), 64'(0));
        finish_sim();
    end

endmodule
